// File: rtl/tcp_tx_msg_noc_if_out_ctrl.sv
// NoC response emitter for the TCP TX tile: turns one poller buffer-space response into a header+body flit pair.
// Optional build macro TCP_TX_PTR_ACK_EN adds a round-robin tail-pointer ACK source sent as a single header flit.
module tcp_tx_msg_noc_if_out_ctrl #(
  parameter int          NOC_W         = 512,
  parameter int          XY_W          = 4,
  parameter int          FBITS_W       = 4,
  parameter int          FLOWID_W      = 8,
  parameter int          PTR_W         = 32,
  parameter int          SRC_X         = 0,
  parameter int          SRC_Y         = 0,
  parameter int          SRC_FBITS     = 0,
  parameter logic [7:0]  RESP_MSG_TYPE = 8'h11,
  parameter logic [7:0]  ACK_MSG_TYPE  = 8'h12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                poller_noc_if_resp_val,
  input  logic [FLOWID_W-1:0] poller_noc_if_resp_flowid,
  input  logic [PTR_W-1:0]    poller_noc_if_resp_ptr,
  input  logic [PTR_W-1:0]    poller_noc_if_resp_len,
  input  logic [XY_W-1:0]     poller_noc_if_resp_dst_x,
  input  logic [XY_W-1:0]     poller_noc_if_resp_dst_y,
  input  logic [FBITS_W-1:0]  poller_noc_if_resp_dst_fbits,
  output logic                noc_if_poller_resp_rdy,
`ifdef TCP_TX_PTR_ACK_EN
  input  logic                tail_ptr_noc_if_ack_val,
  input  logic [FLOWID_W-1:0] tail_ptr_noc_if_ack_flowid,
  input  logic [XY_W-1:0]     tail_ptr_noc_if_ack_dst_x,
  input  logic [XY_W-1:0]     tail_ptr_noc_if_ack_dst_y,
  input  logic [FBITS_W-1:0]  tail_ptr_noc_if_ack_dst_fbits,
  output logic                noc_if_tail_ptr_ack_rdy,
`endif
  output logic                tcp_tx_ptr_if_noc_val,
  output logic [NOC_W-1:0]    tcp_tx_ptr_if_noc_data,
  input  logic                noc_tcp_tx_ptr_if_rdy,
  output logic [1:0]          o_dbg_state
);

  // Handshake rule on every channel: a transfer happens on a rising clk edge where
  // val and rdy are both high; a producer holding val keeps its data unchanged until then.

  localparam int HDR_W  = 2 * (2 * XY_W + FBITS_W + 8);
  localparam int BODY_W = FLOWID_W + 2 * PTR_W;

  localparam logic [XY_W-1:0]    L_SRC_X     = XY_W'(SRC_X);
  localparam logic [XY_W-1:0]    L_SRC_Y     = XY_W'(SRC_Y);
  localparam logic [FBITS_W-1:0] L_SRC_FBITS = FBITS_W'(SRC_FBITS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HDR     = 2'd1,
    S_BODY    = 2'd2
`ifdef TCP_TX_PTR_ACK_EN
    ,S_ACK_HDR = 2'd3
`endif
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [FLOWID_W-1:0] r_flowid;
  logic [PTR_W-1:0]    r_ptr;
  logic [PTR_W-1:0]    r_len;
  logic [XY_W-1:0]     r_dst_x;
  logic [XY_W-1:0]     r_dst_y;
  logic [FBITS_W-1:0]  r_dst_fbits;

  logic                w_idle;
  logic                w_acc_resp;
  logic                w_is_ack;
  logic [7:0]          w_msg_len;
  logic [7:0]          w_msg_type;
  logic [HDR_W-1:0]    w_hdr;

  assign w_idle = (r_state == S_IDLE) && !rst;

`ifdef TCP_TX_PTR_ACK_EN
  // r_last_grant: 1 = ACK source was granted last, 0 = poller was granted last.
  logic r_last_grant;
  logic w_grant_ack;
  logic w_acc_ack;

  assign w_grant_ack = tail_ptr_noc_if_ack_val &&
                       (!poller_noc_if_resp_val || !r_last_grant);
  assign w_acc_ack   = w_idle && w_grant_ack;
  assign w_acc_resp  = w_idle && poller_noc_if_resp_val && !w_grant_ack;
  assign noc_if_poller_resp_rdy  = w_idle && !w_grant_ack;
  assign noc_if_tail_ptr_ack_rdy = w_idle && w_grant_ack;
  assign w_is_ack = (r_state == S_ACK_HDR);
`else
  assign w_acc_resp = w_idle && poller_noc_if_resp_val;
  assign noc_if_poller_resp_rdy = w_idle;
  assign w_is_ack = 1'b0;
`endif

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_acc_resp) begin
          w_next_state = S_HDR;
        end
`ifdef TCP_TX_PTR_ACK_EN
        else if (w_acc_ack) begin
          w_next_state = S_ACK_HDR;
        end
`endif
      end
      S_HDR: begin
        if (noc_tcp_tx_ptr_if_rdy) begin
          w_next_state = S_BODY;
        end
      end
      S_BODY: begin
        if (noc_tcp_tx_ptr_if_rdy) begin
          w_next_state = S_IDLE;
        end
      end
`ifdef TCP_TX_PTR_ACK_EN
      S_ACK_HDR: begin
        if (noc_tcp_tx_ptr_if_rdy) begin
          w_next_state = S_IDLE;
        end
      end
`endif
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_flowid    <= '0;
      r_ptr       <= '0;
      r_len       <= '0;
      r_dst_x     <= '0;
      r_dst_y     <= '0;
      r_dst_fbits <= '0;
`ifdef TCP_TX_PTR_ACK_EN
      r_last_grant <= 1'b1;
`endif
    end else begin
      r_state <= w_next_state;
      if (w_acc_resp) begin
        r_flowid    <= poller_noc_if_resp_flowid;
        r_ptr       <= poller_noc_if_resp_ptr;
        r_len       <= poller_noc_if_resp_len;
        r_dst_x     <= poller_noc_if_resp_dst_x;
        r_dst_y     <= poller_noc_if_resp_dst_y;
        r_dst_fbits <= poller_noc_if_resp_dst_fbits;
`ifdef TCP_TX_PTR_ACK_EN
        r_last_grant <= 1'b0;
`endif
      end
`ifdef TCP_TX_PTR_ACK_EN
      // The ACK reuses the flow/destination registers; ptr/len are irrelevant to it.
      if (w_acc_ack) begin
        r_flowid     <= tail_ptr_noc_if_ack_flowid;
        r_dst_x      <= tail_ptr_noc_if_ack_dst_x;
        r_dst_y      <= tail_ptr_noc_if_ack_dst_y;
        r_dst_fbits  <= tail_ptr_noc_if_ack_dst_fbits;
        r_last_grant <= 1'b1;
      end
`endif
    end
  end

  assign w_msg_len  = w_is_ack ? 8'd0 : 8'd1;
  assign w_msg_type = w_is_ack ? ACK_MSG_TYPE : RESP_MSG_TYPE;
  assign w_hdr = {r_dst_x, r_dst_y, r_dst_fbits, w_msg_len,
                  L_SRC_X, L_SRC_Y, L_SRC_FBITS, w_msg_type};

  // Flit data depends only on registers and state, so it cannot move under backpressure.
  always_comb begin
    tcp_tx_ptr_if_noc_val  = 1'b0;
    tcp_tx_ptr_if_noc_data = '0;
    if (!rst) begin
      if (r_state == S_HDR || w_is_ack) begin
        tcp_tx_ptr_if_noc_val = 1'b1;
        tcp_tx_ptr_if_noc_data[NOC_W-1 -: HDR_W] = w_hdr;
        if (w_is_ack) begin
          tcp_tx_ptr_if_noc_data[NOC_W-1-HDR_W -: FLOWID_W] = r_flowid;
        end
      end else if (r_state == S_BODY) begin
        tcp_tx_ptr_if_noc_val = 1'b1;
        tcp_tx_ptr_if_noc_data[NOC_W-1 -: BODY_W] = {r_flowid, r_ptr, r_len};
      end
    end
  end

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_tcp_tx_msg_noc_if_out_ctrl.sv
// Directed bench for tcp_tx_msg_noc_if_out_ctrl (default build): scoreboard of expected flits plus state/handshake checks.
module tb_tcp_tx_msg_noc_if_out_ctrl;

  localparam int NOC_W = 512;

  logic             clk;
  logic             rst;
  logic             resp_val;
  logic [7:0]       resp_flowid;
  logic [31:0]      resp_ptr;
  logic [31:0]      resp_len;
  logic [3:0]       resp_dst_x;
  logic [3:0]       resp_dst_y;
  logic [3:0]       resp_dst_fbits;
  logic             resp_rdy;
  logic             noc_val;
  logic [NOC_W-1:0] noc_data;
  logic             noc_rdy;
  logic [1:0]       dbg_state;

  logic [NOC_W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  tcp_tx_msg_noc_if_out_ctrl dut (
    .clk                          (clk),
    .rst                          (rst),
    .poller_noc_if_resp_val       (resp_val),
    .poller_noc_if_resp_flowid    (resp_flowid),
    .poller_noc_if_resp_ptr       (resp_ptr),
    .poller_noc_if_resp_len       (resp_len),
    .poller_noc_if_resp_dst_x     (resp_dst_x),
    .poller_noc_if_resp_dst_y     (resp_dst_y),
    .poller_noc_if_resp_dst_fbits (resp_dst_fbits),
    .noc_if_poller_resp_rdy       (resp_rdy),
    .tcp_tx_ptr_if_noc_val        (noc_val),
    .tcp_tx_ptr_if_noc_data       (noc_data),
    .noc_tcp_tx_ptr_if_rdy        (noc_rdy),
    .o_dbg_state                  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [NOC_W-1:0] obs, input logic [NOC_W-1:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  function automatic logic [NOC_W-1:0] mk_hdr(input logic [3:0] dx, input logic [3:0] dy,
                                               input logic [3:0] df);
    logic [NOC_W-1:0] h;
    h = '0;
    h[511:508] = dx;
    h[507:504] = dy;
    h[503:500] = df;
    h[499:492] = 8'd1;
    h[479:472] = 8'h11;
    return h;
  endfunction

  function automatic logic [NOC_W-1:0] mk_body(input logic [7:0] f, input logic [31:0] p,
                                                input logic [31:0] l);
    logic [NOC_W-1:0] b;
    b = '0;
    b[511:504] = f;
    b[503:472] = p;
    b[471:440] = l;
    return b;
  endfunction

  // scoreboard monitor: pops on every flit handshake, and checks hold-under-backpressure
  logic             prev_hold = 1'b0;
  logic [NOC_W-1:0] prev_data = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_val", noc_val, 1);
        chk("hold_data", noc_data, prev_data);
      end
      if (noc_val && noc_rdy) begin
        if (exp_q.size() == 0) begin
          chk("flit_expected", exp_q.size(), 1);
        end else begin
          chk("flit", noc_data, exp_q.pop_front());
        end
      end
      prev_hold = noc_val && !noc_rdy;
      prev_data = noc_data;
    end
  end

  // driver: call just after a posedge; returns just after the posedge that accepted the response
  task automatic send_resp(input logic [7:0] f, input logic [31:0] p, input logic [31:0] l,
                           input logic [3:0] dx, input logic [3:0] dy, input logic [3:0] df,
                           input bit hold, input bit push_body, output int acc);
    bit got;
    got = 1'b0;
    acc = 0;
    resp_val       = 1'b1;
    resp_flowid    = f;
    resp_ptr       = p;
    resp_len       = l;
    resp_dst_x     = dx;
    resp_dst_y     = dy;
    resp_dst_fbits = df;
    exp_q.push_back(mk_hdr(dx, dy, df));
    if (push_body) exp_q.push_back(mk_body(f, p, l));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp_rdy) begin
        got = 1'b1;
        acc = cyc;
        break;
      end
    end
    chk("resp_accept", got, 1);
    @(posedge clk);
    #1;
    if (!hold) resp_val = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !noc_val) break;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    int acc0;
    int acc1;
    int acc2;
    rst = 1'b1;
    resp_val = 1'b0;
    resp_flowid = '0;
    resp_ptr = '0;
    resp_len = '0;
    resp_dst_x = '0;
    resp_dst_y = '0;
    resp_dst_fbits = '0;
    noc_rdy = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_rdy", resp_rdy, 0);
    chk("rst_val", noc_val, 0);
    chk("rst_data", noc_data, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_resp_rdy", resp_rdy, 1);
    chk("idle_val", noc_val, 0);
    chk("idle_state", dbg_state, 0);

    // basic response, no backpressure
    @(posedge clk);
    #1 noc_rdy = 1'b1;
    send_resp(8'd5, 32'h100, 32'h40, 4'd2, 4'd3, 4'd0, 1'b0, 1'b1, acc0);
    @(negedge clk);
    chk("basic_hdr_state", dbg_state, 1);
    chk("basic_hdr_val", noc_val, 1);
    chk("basic_hdr_rdy_low", resp_rdy, 0);
    @(negedge clk);
    chk("basic_body_state", dbg_state, 2);
    chk("basic_body_rdy_low", resp_rdy, 0);
    drain();

    // header backpressure for 4 cycles
    @(posedge clk);
    #1 noc_rdy = 1'b0;
    send_resp(8'd9, 32'hDEAD_BEEF, 32'h0000_0800, 4'd15, 4'd1, 4'd7, 1'b0, 1'b1, acc0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_val", noc_val, 1);
      chk("bp_state", dbg_state, 1);
      chk("bp_data", noc_data, mk_hdr(4'd15, 4'd1, 4'd7));
    end
    @(posedge clk);
    #1 noc_rdy = 1'b1;
    @(negedge clk);
    chk("bp_hdr_on_rdy", dbg_state, 1);
    @(negedge clk);
    chk("bp_body_next", dbg_state, 2);
    drain();

    // back-to-back with resp_val held high
    @(posedge clk);
    #1;
    send_resp(8'd10, 32'h1000, 32'h20, 4'd0, 4'd1, 4'd2, 1'b1, 1'b1, acc0);
    send_resp(8'd11, 32'h2000, 32'h21, 4'd1, 4'd2, 4'd3, 1'b1, 1'b1, acc1);
    send_resp(8'd12, 32'h3000, 32'h22, 4'd2, 4'd3, 4'd4, 1'b0, 1'b1, acc2);
    chk("b2b_gap_0_1", acc1 - acc0, 3);
    chk("b2b_gap_1_2", acc2 - acc1, 3);
    drain();

    // reset while in BODY
    @(posedge clk);
    #1 noc_rdy = 1'b0;
    send_resp(8'h33, 32'hAAAA_0000, 32'h10, 4'd4, 4'd5, 4'd6, 1'b0, 1'b0, acc0);
    noc_rdy = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 noc_rdy = 1'b0;
    @(negedge clk);
    chk("mid_body_state", dbg_state, 2);
    chk("mid_body_val", noc_val, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_resp_rdy", resp_rdy, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    noc_rdy = 1'b1;
    @(negedge clk);
    chk("post_rst_val", noc_val, 0);
    chk("post_rst_state", dbg_state, 0);
    @(posedge clk);
    #1;
    send_resp(8'h44, 32'h5555_1234, 32'h99, 4'd8, 4'd9, 4'd10, 1'b0, 1'b1, acc0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
